// File: rtl/regbank_xfer_seq_pkg.sv
// Shared constants and encodings for the register-bank transfer sequencer.
package regbank_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_STORE = 1'b0;
    localparam logic DIR_LOAD  = 1'b1;

endpackage

// File: rtl/regbank_xfer_seq_if.sv
// Register-bank ports plus the store (out) and load (in) valid/ready streams.
interface regbank_xfer_seq_if import regbank_pkg::*; ();

    logic [AW-1:0] rs;
    logic [DW-1:0] rd1;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          write;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output rs, rd, data, write, out_valid, out_data, in_ready,
        input  rd1, out_ready, in_valid, in_data
    );

    modport slave (
        input  rs, rd, data, write, out_valid, out_data, in_ready,
        output rd1, out_ready, in_valid, in_data
    );

endinterface

// File: rtl/regbank_xfer_seq_prio_enc.sv
// Combinational lowest-set-bit encoder; none_o flags an all-zero vector.
module regbank_prio_enc import regbank_pkg::*; (
    input  logic [NREG-1:0] vec_i,
    output logic [AW-1:0]   idx_o,
    output logic            none_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!found && vec_i[i]) begin
                idx_o = AW'(i);
                found = 1'b1;
            end
        end
        none_o = !found;
    end

endmodule

// File: rtl/regbank_xfer_seq.sv
// Multi-register store/load sequencer driving the register bank ports.
// Optional beat counter output enabled by defining XFER_COUNT_EN.
module regbank_xfer_seq import regbank_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                dir,
    input  logic [NREG-1:0]     mask,
    output logic                busy,
    output logic                done,
`ifdef XFER_COUNT_EN
    output logic [AW:0]         xfer_count,
`endif
    regbank_xfer_seq_if.master  bus
);

    state_e          state_q;
    logic            dir_q;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            busy_q;
    logic            done_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic [AW-1:0]   rs_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   data_q;

    logic [AW-1:0]   idx;
    logic            none;
    logic            st_xfer;
    logic            ld_xfer;
    logic            beat;

    regbank_prio_enc u_prio_enc (
        .vec_i  (pending_q),
        .idx_o  (idx),
        .none_o (none)
    );

    assign st_xfer   = (state_q == XFER) && (dir_q == DIR_STORE);
    assign ld_xfer   = (state_q == XFER) && (dir_q == DIR_LOAD);
    assign beat      = (st_xfer && bus.out_ready) || (ld_xfer && bus.in_valid);
    assign pending_d = pending_q & ~(NREG'(1) << idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= DIR_STORE;
            pending_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            rs_q        <= '0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dir_q     <= dir;
                        pending_q <= mask;
                        busy_q    <= 1'b1;
                        if (mask == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= XFER;
                            out_valid_q <= (dir == DIR_STORE);
                            in_ready_q  <= (dir == DIR_LOAD);
                        end
                    end
                end
                XFER: begin
                    // Shadow the live addresses/data so they hold once XFER ends.
                    if (dir_q == DIR_STORE) begin
                        rs_q <= idx;
                    end else begin
                        rd_q   <= idx;
                        data_q <= bus.in_data;
                    end
                    if (beat) begin
                        pending_q <= pending_d;
                    end
                    if (none || (beat && (pending_d == '0))) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = bus.rd1;
    assign bus.rs        = st_xfer ? idx : rs_q;
    assign bus.rd        = ld_xfer ? idx : rd_q;
    assign bus.data      = ld_xfer ? bus.in_data : data_q;
    assign bus.write     = ld_xfer && bus.in_valid;

`ifdef XFER_COUNT_EN
    localparam logic [AW:0] CNT_ONE = 1;

    logic [AW:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            xfer_count_q <= '0;
        end else if (beat) begin
            xfer_count_q <= xfer_count_q + CNT_ONE;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_regbank_xfer_seq.sv
// Bench for regbank_xfer_seq: behavioural bank, vector table and scoreboard.
module tb_regbank_xfer_seq;
    import regbank_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            dir;
    logic [NREG-1:0] mask;
    logic            busy;
    logic            done;
`ifdef XFER_COUNT_EN
    logic [AW:0]     xfer_count;
`endif

    regbank_xfer_seq_if bus ();

    regbank_xfer_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .mask       (mask),
        .busy       (busy),
        .done       (done),
`ifdef XFER_COUNT_EN
        .xfer_count (xfer_count),
`endif
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural register bank with a bench-side preload port.
    logic [DW-1:0] bank   [NREG];
    logic [DW-1:0] shadow [NREG];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) bank[pl_addr] <= pl_data;
        else if (bus.write) bank[bus.rd] <= bus.data;
    end
    assign bus.rd1 = bank[bus.rs];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
    } beat_t;
    beat_t sb_q[$];

    typedef struct {
        logic            dir;
        logic [NREG-1:0] mask;
        int unsigned     sf;
        int unsigned     sb;
        logic            spur;
        logic [DW-1:0]   w0;
        logic [DW-1:0]   w1;
        int unsigned     exp_beats;
        int unsigned     exp_done;
    } vec_t;
    vec_t vecs[11];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ld_word(input vec_t v, input int unsigned k);
        if (k == 0) return v.w0;
        if (k == 1) return v.w1;
        return v.w0 ^ (32'h9E3779B9 * k);
    endfunction

    task automatic run_vec(input vec_t v, input int vi);
        int unsigned   k;
        int unsigned   beats;
        int unsigned   done_cyc;
        int unsigned   next_hs;
        logic [AW-1:0] last_addr;
        logic          hs;
        logic          wr_in_store;
        logic          busy_bad;
        logic          idle_streams;
        beat_t         b;

        k = 0;
        last_addr = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (v.mask[i]) begin
                b.addr = AW'(i);
                b.word = (v.dir == DIR_STORE) ? shadow[i] : ld_word(v, k);
                if (v.dir == DIR_LOAD) shadow[i] = b.word;
                sb_q.push_back(b);
                last_addr = AW'(i);
                k++;
            end
        end

        start = 1'b1;
        dir   = v.dir;
        mask  = v.mask;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d busy_start_cycle", vi), busy, 0);

        beats = 0;
        done_cyc = 0;
        next_hs = v.sf;
        wr_in_store = 1'b0;
        busy_bad = 1'b0;
        idle_streams = 1'b1;
        for (int unsigned cyc = 2; cyc <= 200; cyc++) begin
            next_cycle();
            start = v.spur && (cyc <= 3);
            mask  = ~v.mask;
            dir   = v.spur ? ~v.dir : v.dir;
            hs = ((cyc - 2) == next_hs);
            if (v.dir == DIR_STORE) begin
                bus.out_ready = hs;
                bus.in_valid  = 1'b0;
            end else begin
                bus.out_ready = 1'b0;
                bus.in_valid  = hs;
                bus.in_data   = (hs && sb_q.size() > 0) ? sb_q[0].word : (32'hBAD0_0000 | cyc);
            end
            @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (v.dir == DIR_STORE) begin
                if (bus.write) wr_in_store = 1'b1;
                if (bus.out_valid && sb_q.size() > 0) begin
                    check($sformatf("v%0d out_data", vi), bus.out_data, sb_q[0].word);
                    check($sformatf("v%0d rs", vi), bus.rs, sb_q[0].addr);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) check($sformatf("v%0d extra_beat", vi), 1, 0);
                    else void'(sb_q.pop_front());
                    beats++;
                    next_hs = cyc - 2 + 1 + v.sb;
                end
            end else if (bus.write) begin
                check($sformatf("v%0d in_ready", vi), bus.in_ready, 1);
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d extra_beat", vi), 1, 0);
                end else begin
                    check($sformatf("v%0d rd", vi), bus.rd, sb_q[0].addr);
                    check($sformatf("v%0d data", vi), bus.data, sb_q[0].word);
                    void'(sb_q.pop_front());
                end
                beats++;
                next_hs = cyc - 2 + 1 + v.sb;
            end
            if (done) begin
                done_cyc = cyc;
                idle_streams = !bus.out_valid && !bus.in_ready && !bus.write;
                break;
            end
        end

        check($sformatf("v%0d done_cycle", vi), done_cyc, v.exp_done);
        check($sformatf("v%0d beats", vi), beats, v.exp_beats);
        check($sformatf("v%0d sb_left", vi), sb_q.size(), 0);
        check($sformatf("v%0d busy_during", vi), busy_bad, 0);
        check($sformatf("v%0d streams_in_done", vi), idle_streams, 1);
        if (v.dir == DIR_STORE) check($sformatf("v%0d write_in_store", vi), wr_in_store, 0);
        if (v.exp_beats > 0) begin
            if (v.dir == DIR_STORE) check($sformatf("v%0d rs_hold", vi), bus.rs, last_addr);
            else                    check($sformatf("v%0d rd_hold", vi), bus.rd, last_addr);
        end
`ifdef XFER_COUNT_EN
        check($sformatf("v%0d xfer_count", vi), xfer_count, v.exp_beats);
`endif
        sb_q.delete();

        next_cycle();
        start = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        if (done_cyc == 0) reset = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d done_after", vi), done, 0);
        check($sformatf("v%0d busy_after", vi), busy, 0);
`ifdef XFER_COUNT_EN
        if (done_cyc != 0) check($sformatf("v%0d xfer_count_hold", vi), xfer_count, v.exp_beats);
`endif
        next_cycle();
        reset = 1'b0;
        for (int unsigned i = 0; i < NREG; i++)
            check($sformatf("v%0d bank_r%0d", vi, i), bank[i], shadow[i]);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        mask  = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        //         dir        mask      sf sb spur w0            w1            beats done
        vecs[0]  = '{DIR_STORE, 16'h0009, 0, 0, 0, 32'h0,        32'h0,        2,    4};
        vecs[1]  = '{DIR_STORE, 16'h0008, 3, 0, 0, 32'h0,        32'h0,        1,    6};
        vecs[2]  = '{DIR_LOAD,  16'h8001, 0, 2, 0, 32'h11,       32'hDEADBEEF, 2,    6};
        vecs[3]  = '{DIR_STORE, 16'h0000, 0, 0, 0, 32'h0,        32'h0,        0,    2};
        vecs[4]  = '{DIR_LOAD,  16'h0000, 0, 0, 0, 32'h0,        32'h0,        0,    2};
        vecs[5]  = '{DIR_STORE, 16'hFFFF, 0, 0, 0, 32'h0,        32'h0,        16,   18};
        vecs[6]  = '{DIR_LOAD,  16'hFFFF, 0, 1, 0, 32'hC0FFEE00, 32'h12345678, 16,   33};
        vecs[7]  = '{DIR_STORE, 16'h8421, 1, 1, 0, 32'h0,        32'h0,        4,    10};
        vecs[8]  = '{DIR_LOAD,  16'h0F0F, 2, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 8,    12};
        vecs[9]  = '{DIR_STORE, 16'h8000, 0, 0, 0, 32'h0,        32'h0,        1,    3};
        vecs[10] = '{DIR_STORE, 16'h0006, 1, 0, 1, 32'h0,        32'h0,        2,    5};

        for (int unsigned i = 0; i < NREG; i++) begin
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 0) ? 32'd234 : (i == 3) ? 32'd340 : (32'h100 + 32'h01010101 * i);
            shadow[i] = pl_data;
            next_cycle();
        end
        pl_en = 1'b0;

        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst write", bus.write, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst in_ready", bus.in_ready, 0);
        check("rst rs", bus.rs, 0);
        check("rst rd", bus.rd, 0);
        check("rst data", bus.data, 0);
`ifdef XFER_COUNT_EN
        check("rst xfer_count", xfer_count, 0);
`endif
        next_cycle();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset mid-load: two beats land, then reset with valid low.
        start = 1'b1;
        dir   = DIR_LOAD;
        mask  = 16'h00F0;
        next_cycle();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4444_0004;
        @(negedge clk);
        check("rml write_r4", bus.write, 1);
        check("rml rd_r4", bus.rd, 4);
        next_cycle();
        bus.in_data = 32'h5555_0005;
        @(negedge clk);
        check("rml rd_r5", bus.rd, 5);
        next_cycle();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h6666_0006;
        @(negedge clk);
        check("rml busy", busy, 0);
        check("rml done", done, 0);
        check("rml write", bus.write, 0);
        check("rml out_valid", bus.out_valid, 0);
        check("rml in_ready", bus.in_ready, 0);
        check("rml rs", bus.rs, 0);
        check("rml rd", bus.rd, 0);
        check("rml data", bus.data, 0);
`ifdef XFER_COUNT_EN
        check("rml xfer_count", xfer_count, 0);
`endif
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        shadow[4] = 32'h4444_0004;
        shadow[5] = 32'h5555_0005;
        for (int unsigned i = 4; i < 8; i++)
            check($sformatf("rml bank_r%0d", i), bank[i], shadow[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
